// File: rtl/memresp_pkg.sv
// rtl/memresp_pkg.sv - shared types and constants for the memresp memory responder
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif

package memresp_pkg;

    localparam int DEPTH_LOG2_DEFAULT = 8;
    localparam int ADDR_W             = `HBIT_ADDR + 1;
    localparam int DATA_W             = `SIZE_DATA;

    // One response buffer entry: read data (or written data for an ack),
    // full request address and response type.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    // A request may be taken only while fewer than two responses are owed
    // (buffered plus in flight). Uses registered state only, so ready never
    // depends combinationally on the response-side ready.
    function automatic logic credit_ok(input logic [1:0] count, input logic inflight);
        return ({1'b0, count} + {2'b00, inflight}) < 3'd2;
    endfunction

endpackage

// File: rtl/memresp_if.sv
// rtl/memresp_if.sv - request/response channel bundle between initiator and memresp
interface memresp_if;
    import memresp_pkg::*;

    logic              iw_req_valid;
    logic              ow_req_ready;
    logic              iw_req_we;
    logic [ADDR_W-1:0] iw_req_addr;
    logic [DATA_W-1:0] iw_req_wdata;
    logic              ow_rsp_valid;
    logic              iw_rsp_ready;
    logic [DATA_W-1:0] ow_rsp_rdata;
    logic [ADDR_W-1:0] ow_rsp_addr;
    logic              ow_rsp_we;

    modport master (
        output iw_req_valid, iw_req_we, iw_req_addr, iw_req_wdata, iw_rsp_ready,
        input  ow_req_ready, ow_rsp_valid, ow_rsp_rdata, ow_rsp_addr, ow_rsp_we
    );

    modport slave (
        input  iw_req_valid, iw_req_we, iw_req_addr, iw_req_wdata, iw_rsp_ready,
        output ow_req_ready, ow_rsp_valid, ow_rsp_rdata, ow_rsp_addr, ow_rsp_we
    );

endinterface

// File: rtl/memresp_respfifo.sv
// rtl/memresp_respfifo.sv - 2-entry response FIFO with count output
module memresp_respfifo #(
    parameter int W = 8
) (
    input  logic         iw_clk,
    input  logic         iw_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         pop_ok;

    // Popping an empty buffer is ignored.
    assign pop_ok = pop && (count != 2'd0);
    assign head   = slot0;

    // Slot 0 is always the head; slot 1 holds the second entry when full.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/memresp.sv
// rtl/memresp.sv - single-port memory responder; MEMRESP_WRITE_ACK_EN enables write acks
module memresp
    import memresp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic     iw_clk,
    input  logic     iw_rst,
    memresp_if.slave bus
);

    logic [DATA_W-1:0]     mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept;
    logic                  stage_load;
    rsp_t                  stage_d;
    rsp_t                  inflight_q;
    logic                  inflight_v;
    logic [RSP_W-1:0]      fifo_head;
    rsp_t                  head;
    logic [1:0]            fifo_count;
    logic                  rsp_pop;

    // Upper address bits are dropped for indexing so the array wraps.
    assign idx    = bus.iw_req_addr[DEPTH_LOG2-1:0];
    assign accept = bus.iw_req_valid && bus.ow_req_ready;

    // Decide what enters the in-flight stage at an accept edge.
    always_comb begin
        stage_load   = 1'b0;
        stage_d.data = mem[idx];
        stage_d.addr = bus.iw_req_addr;
        stage_d.we   = 1'b0;
`ifdef MEMRESP_WRITE_ACK_EN
        stage_load = accept;
        if (bus.iw_req_we) begin
            stage_d.data = bus.iw_req_wdata;
            stage_d.we   = 1'b1;
        end
`else
        stage_load = accept && !bus.iw_req_we;
`endif
    end

    // Array write at the accept edge; contents survive reset.
    always_ff @(posedge iw_clk) begin
        if (accept && bus.iw_req_we) begin
            mem[idx] <= bus.iw_req_wdata;
        end
    end

    // In-flight stage: holds a response for one edge before it enters the FIFO.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            inflight_v <= 1'b0;
            inflight_q <= '0;
        end else begin
            inflight_v <= stage_load;
            if (stage_load) inflight_q <= stage_d;
        end
    end

    memresp_respfifo #(
        .W (RSP_W)
    ) u_respfifo (
        .iw_clk    (iw_clk),
        .iw_rst    (iw_rst),
        .push      (inflight_v),
        .push_data (inflight_q),
        .pop       (rsp_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign head    = fifo_head;
    assign rsp_pop = bus.ow_rsp_valid && bus.iw_rsp_ready;

    assign bus.ow_req_ready = credit_ok(fifo_count, inflight_v);
    assign bus.ow_rsp_valid = (fifo_count != 2'd0);
    assign bus.ow_rsp_rdata = head.data;
    assign bus.ow_rsp_addr  = head.addr;
    assign bus.ow_rsp_we    = head.we;

endmodule

// File: tb/tb_memresp.sv
// tb/tb_memresp.sv - self-checking bench for memresp with a transaction-level reference model
module tb_memresp;
    import memresp_pkg::*;

`ifdef MEMRESP_WRITE_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        logic              we;
        int                vis;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    memresp_if bus ();

    memresp #(.DEPTH_LOG2(8)) dut (
        .iw_clk (clk),
        .iw_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mm [256];
    ent_t              q[$];
    int                edges = 0;
    logic              acc;
    int                acc_edge = 0;
    logic [DATA_W-1:0] last_pop_data;
    logic [ADDR_W-1:0] last_pop_addr;
    logic              last_pop_we;
    int                last_pop_edge = 0;
    int                pop_cnt = 0;
    int                ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic exp_ready;
        logic exp_valid;
        logic pop;
        @(negedge clk);
        exp_ready = (q.size() < 2);
        exp_valid = (q.size() > 0) && (q[0].vis <= edges);
        chk("req_ready", 32'(bus.ow_req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(bus.ow_rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_rdata", 32'(bus.ow_rsp_rdata), 32'(q[0].d));
            chk("rsp_addr",  32'(bus.ow_rsp_addr),  32'(q[0].a));
            chk("rsp_we",    32'(bus.ow_rsp_we),    32'(q[0].we));
        end
        if (bus.ow_rsp_valid && bus.iw_rsp_ready) begin
            last_pop_data = bus.ow_rsp_rdata;
            last_pop_addr = bus.ow_rsp_addr;
            last_pop_we   = bus.ow_rsp_we;
            last_pop_edge = edges + 1;
            pop_cnt++;
            if (bus.ow_rsp_we) ack_cnt++;
        end
        acc = bus.iw_req_valid && exp_ready;
        pop = exp_valid && bus.iw_rsp_ready;
        @(posedge clk);
        edges++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            acc_edge = edges;
            if (bus.iw_req_we) begin
                if (ACK != 0) q.push_back('{bus.iw_req_wdata, bus.iw_req_addr, 1'b1, edges + 1});
                mm[bus.iw_req_addr[7:0]] = bus.iw_req_wdata;
            end else begin
                q.push_back('{mm[bus.iw_req_addr[7:0]], bus.iw_req_addr, 1'b0, edges + 1});
            end
        end
        #1;
    endtask

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit done = 0;
        bus.iw_req_valid = 1'b1;
        bus.iw_req_we    = we;
        bus.iw_req_addr  = a;
        bus.iw_req_wdata = d;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (acc) done = 1;
        end
        chk("req_accept_timeout", 32'(done), 32'd1);
        bus.iw_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.iw_req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.ow_rsp_valid), 32'd0);
        chk({tag, "_ready"}, 32'(bus.ow_req_ready), 32'd1);
        chk({tag, "_rdata"}, 32'(bus.ow_rsp_rdata), 32'd0);
        chk({tag, "_addr"},  32'(bus.ow_rsp_addr),  32'd0);
        chk({tag, "_we"},    32'(bus.ow_rsp_we),    32'd0);
    endtask

    // Asynchronous reset pulse spanning one rising edge.
    task automatic pulse_reset();
        bus.iw_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1 reset_outputs_zero("rst_async");
        q.delete();
        @(posedge clk);
        edges++;
        #1 reset_outputs_zero("rst_held");
        #1 rst = 1'b0;
        #1 reset_outputs_zero("rst_after");
    endtask

    initial begin
        int n_acc;
        int pops_before;
        int acks_before;
        logic [ADDR_W-1:0] ra;

        bus.iw_req_valid = 1'b0;
        bus.iw_req_we    = 1'b0;
        bus.iw_req_addr  = '0;
        bus.iw_req_wdata = '0;
        bus.iw_rsp_ready = 1'b1;

        pulse_reset();

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < 256; i++) do_req(1'b1, ADDR_W'(i), DATA_W'($urandom));
        idle(4);

        // Write then read on consecutive cycles; response two edges after the read accept.
        do_req(1'b1, 12'h010, 24'h00ABCD);
        do_req(1'b0, 12'h010, '0);
        ra = 12'h010;
        n_acc = acc_edge;
        idle(4);
        chk("wr_rd_data",    32'(last_pop_data), 32'h00ABCD);
        chk("wr_rd_addr",    32'(last_pop_addr), 32'(ra));
        chk("wr_rd_we",      32'(last_pop_we),   32'd0);
        chk("wr_rd_latency", 32'(last_pop_edge - n_acc), 32'd2);

        // Address wrap: 0x105 aliases 0x005 but returns the full address.
        do_req(1'b1, 12'h005, 24'h000055);
        do_req(1'b0, 12'h105, '0);
        idle(4);
        chk("wrap_data", 32'(last_pop_data), 32'h000055);
        chk("wrap_addr", 32'(last_pop_addr), 32'h105);

        // Back-pressure: exactly two reads taken, ready then stays low.
        bus.iw_rsp_ready = 1'b0;
        bus.iw_req_valid = 1'b1;
        bus.iw_req_we    = 1'b0;
        bus.iw_req_addr  = 12'h001;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc) begin
                n_acc++;
                bus.iw_req_addr = bus.iw_req_addr + 12'h001;
            end
        end
        chk("bp_accepted", 32'(n_acc), 32'd2);
        chk("bp_ready_low", 32'(bus.ow_req_ready), 32'd0);
        bus.iw_req_valid = 1'b0;
        bus.iw_rsp_ready = 1'b1;
        tick();
        chk("bp_first_addr", 32'(last_pop_addr), 32'h001);
        chk("bp_ready_back", 32'(bus.ow_req_ready), 32'd1);
        tick();
        chk("bp_second_addr", 32'(last_pop_addr), 32'h002);
        idle(3);

        // Reset with two responses buffered: nothing stale may appear afterwards.
        bus.iw_rsp_ready = 1'b0;
        do_req(1'b0, 12'h030, '0);
        do_req(1'b0, 12'h031, '0);
        idle(2);
        chk("mid_full_valid", 32'(bus.ow_rsp_valid), 32'd1);
        pulse_reset();
        bus.iw_rsp_ready = 1'b1;
        pops_before = pop_cnt;
        idle(5);
        chk("mid_no_stale", 32'(pop_cnt - pops_before), 32'd0);

        // Write ack: one response only when the ack build option is on.
        acks_before = ack_cnt;
        pops_before = pop_cnt;
        do_req(1'b1, 12'h020, 24'h000777);
        idle(4);
        chk("wack_count", 32'(ack_cnt - acks_before), 32'(ACK));
        chk("wack_pops",  32'(pop_cnt - pops_before), 32'(ACK));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.iw_req_valid = 1'($urandom_range(0, 1));
            bus.iw_req_we    = 1'($urandom_range(0, 1));
            bus.iw_req_addr  = ADDR_W'($urandom_range(0, 4095));
            bus.iw_req_wdata = DATA_W'($urandom);
            bus.iw_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.iw_rsp_ready = 1'b1;
        idle(4);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
